mips_mem_responder: RTL
=======================

# mips_mem_responder

Memory-side responder for the simple MIPS data port. It accepts one load or store request at a time from the core over a valid/ready request channel. It performs the access against an internal word-addressed SRAM after a programmable number of wait states. It returns read data, or a store acknowledge, on a valid/ready response channel, with little-endian byte/half lane steering, sign/zero extension and alignment checking.

## Interface
- `ADDR_W`, default 20: byte-address width. The SRAM holds 2^(ADDR_W-2) 32-bit words.
- `WAIT_CYCLES`, default 2: wait states inserted before each access. Legal range is 0..15.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: responder can accept a request.
- `req_we`, input, 1: 1 = store, 0 = load.
- `req_addr`, input, ADDR_W: byte address.
- `req_size`, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed`, input, 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `req_wdata`, input, 32: store data, taken from the low-order bits (7:0 for byte, 15:0 for half).
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: core accepts the response.
- `rsp_rdata`, output, 32: load result. 0 for stores and for errors.
- `rsp_err`, output, 1: misaligned or illegal-size request.

## Operation
- States and transitions:
  - IDLE: `req_ready`=1. On `req_valid`&`req_ready`, latch we/addr/size/signed/wdata, load `wcnt`=WAIT_CYCLES, and go to WAIT.
  - WAIT: if `wcnt`≠0, decrement. If `wcnt`==0, perform the access, register the result, and go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- `req_ready` is 1 only in IDLE. At most one transaction is outstanding.
- Request fields are sampled only at the accept edge. Later changes on the request inputs are ignored.
- Error check, evaluated on the latched request:
  - err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]≠0).
  - On error: no SRAM write, `rsp_rdata`=0, `rsp_err`=1.
- Word index is `addr[ADDR_W-1:2]`. Lane n covers bits 8n+7:8n and is selected by `addr[1:0]`.
- Store byte: write `wdata[7:0]` into lane `addr[1:0]` only. Other lanes are unchanged.
- Store half: write `wdata[15:0]` into bits 15:0 if `addr[1]`=0, otherwise bits 31:16.
- Store word: write the full word. Every store response has `rsp_rdata`=0 and `rsp_err`=0.
- Load byte: lane selected by `addr[1:0]`, extended from that lane's bit 7 when `signed`=1, otherwise zero-filled.
- Load half: half selected by `addr[1]`, extended from its bit 15 when `signed`=1.
- Load word: full word. `req_signed` is ignored.
- The SRAM is not cleared by reset. Contents are undefined until written, or until preloaded by `$readmemb` in simulation.

## Timing
- Reset values, applied while `reset`=0 regardless of clock:
  - state=IDLE, `wcnt`=0.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Cycle sequence for a request accepted at edge E0:
  - State is WAIT for cycles E0..E0+WAIT_CYCLES.
  - The SRAM access, read or write, happens at edge E0+WAIT_CYCLES+1.
  - `rsp_valid` is high from that edge.
  - With `rsp_ready` held at 1, the response handshake occurs at edge E0+WAIT_CYCLES+2.
  - `req_ready` is high again in the following cycle.
- Throughput is one transaction per WAIT_CYCLES+3 cycles with no backpressure.
- With WAIT_CYCLES=0, the access happens at E0+1.
- Backpressure: while `rsp_ready`=0 in RESP, `rsp_valid`, `rsp_rdata` and `rsp_err` hold stable. `req_ready` stays 0.
- A read always returns SRAM contents as of the access edge.
- Reset asserted mid-transaction:
  - In WAIT, the transaction is dropped and no write occurs.
  - In RESP, the write has already occurred and the response is discarded.
- `req_valid` asserted outside IDLE is not accepted. The core must hold it until the handshake.
- `rsp_rdata` and `rsp_err` are registered. There is no combinational path from any input to any output.

## Test plan
- Word store then load, WAIT_CYCLES=2:
  - SW 0xDEADBEEF at 0x100 -> ack, with `rsp_valid` at accept+3 and `rdata`=0.
  - LW 0x100 -> `rdata`=0xDEADBEEF, `err`=0.
- Byte lanes:
  - SW 0 at 0x200, then SB 0x80 at 0x203.
  - LW 0x200 -> 0x80000000.
  - LB signed 0x203 -> 0xFFFFFF80.
  - LBU 0x203 -> 0x00000080.
- Halves:
  - SH 0x8001 at 0x302 over 0x11223344.
  - LW -> 0x80013344.
  - LH signed 0x302 -> 0xFFFF8001.
  - LHU 0x300 -> 0x00003344.
- Misaligned and illegal:
  - LW 0x101 -> `err`=1, `rdata`=0.
  - SH 0x301 -> `err`=1, and the word at 0x300 is unchanged.
  - size=11 -> `err`=1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` -> outputs stable, `req_ready`=0, and the handshake completes on the first `rsp_ready`=1 edge.
- Reset abort: assert `reset`=0 one cycle after accepting SW 0xCAFEF00D at 0x400 (previously 0x0) -> outputs at reset values immediately, and a later LW 0x400 returns 0x00000000.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the MIPS data port: one load/store at a time, WAIT_CYCLES wait states,
// then a registered response with lane steering, sign/zero extension and alignment checking.
module mips_mem_responder #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem_q [DEPTH];

  logic                accept;
  logic                access;
  logic                err;
  logic                do_write;
  logic [ADDR_W-3:0]   word_idx;
  logic [1:0]          lane;
  logic [31:0]         rword;
  logic [31:0]         wlanes;
  logic [31:0]         load_val;
  logic [3:0]          be;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign access   = (state_q == S_WAIT) && (wcnt_q == 4'd0);
  assign word_idx = addr_q[ADDR_W-1:2];
  assign lane     = addr_q[1:0];
  assign rword    = mem_q[word_idx];
  assign err      = (size_q == 2'b11) ||
                    ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
  assign do_write = access && we_q && !err;

  // Byte enables and replicated store data for the write; lane extraction for loads.
  always_comb begin
    be       = 4'b1111;
    wlanes   = wdata_q;
    byte_v   = rword[{lane, 3'b000} +: 8];
    half_v   = lane[1] ? rword[31:16] : rword[15:0];
    load_val = rword;
    case (size_q)
      2'b00: begin
        be       = 4'b0001 << lane;
        wlanes   = {4{wdata_q[7:0]}};
        load_val = {{24{signed_q & byte_v[7]}}, byte_v};
      end
      2'b01: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{wdata_q[15:0]}};
        load_val = {{16{signed_q & half_v[15]}}, half_v};
      end
      default: begin
        be       = 4'b1111;
        wlanes   = wdata_q;
        load_val = rword;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          wcnt_d  = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          err_d   = err;
          rdata_d = (err || we_q) ? 32'd0 : load_val;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields are captured only at the accept edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      wdata_q  <= 32'd0;
    end else if (accept) begin
      we_q     <= req_we;
      addr_q   <= req_addr;
      size_q   <= req_size;
      signed_q <= req_signed;
      wdata_q  <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
